// File: rtl/vault_sequencer_if.sv
// rtl/vault_sequencer_if.sv - control/status bundle between the vault sequencer and its environment
interface vault_sequencer_if #(
  parameter int NUM_PHASES = 3
);
  localparam int IW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic                  start;
  logic                  admin_clr;
  logic [NUM_PHASES-1:0] phase_done;
  logic [NUM_PHASES-1:0] phase_fail;
  logic [NUM_PHASES-1:0] phase_en;
  logic [NUM_PHASES-1:0] phase_clr;
  logic [IW-1:0]         cur_phase;
  logic                  unlock;
  logic                  lockout;
  logic                  alarm;
  logic [3:0]            attempts_left;
  logic                  timeout_err;

  modport master (
    output start, admin_clr, phase_done, phase_fail,
    input  phase_en, phase_clr, cur_phase, unlock, lockout, alarm, attempts_left, timeout_err
  );

  modport slave (
    input  start, admin_clr, phase_done, phase_fail,
    output phase_en, phase_clr, cur_phase, unlock, lockout, alarm, attempts_left, timeout_err
  );
endinterface

// File: rtl/vault_sequencer.sv
// rtl/vault_sequencer.sv - multi-phase unlock sequencer with attempt counting, lockout and alarm
// Optional per-phase watchdog is built when VAULT_TIMEOUT_EN is defined.
module vault_sequencer #(
  parameter int NUM_PHASES     = 3,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int UNLOCK_CYCLES  = 8
`ifdef VAULT_TIMEOUT_EN
  ,
  parameter int PHASE_TIMEOUT  = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vault_sequencer_if.slave      bus
);
  localparam int IW   = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int CMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    UNLOCK  = 3'd2,
    LOCKOUT = 3'd3,
    ALARM   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            att_q, att_d;
  logic [NUM_PHASES-1:0] en_q, en_d;
  logic                  unlock_q, lockout_q, alarm_q;
  logic                  timeout_hit;
  logic                  fail_now;
  logic                  done_now;

  assign fail_now = bus.phase_fail[idx_q] | timeout_hit;
  assign done_now = bus.phase_done[idx_q];

`ifdef VAULT_TIMEOUT_EN
  localparam int TW = (PHASE_TIMEOUT > 2) ? $clog2(PHASE_TIMEOUT) : 1;
  logic [TW-1:0] pcnt_q;
  logic          tmo_q;

  assign timeout_hit = (state_q == RUN) && (pcnt_q == TW'(PHASE_TIMEOUT - 1))
                       && !bus.phase_done[idx_q] && !bus.phase_fail[idx_q];

  // Counter restarts whenever a phase is released (entering RUN or advancing idx).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tmo_q <= timeout_hit;
      if (state_d != RUN || state_q != RUN || idx_d != idx_q)
        pcnt_q <= '0;
      else
        pcnt_q <= pcnt_q + 1'b1;
    end
  end

  assign bus.timeout_err = tmo_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (fail_now) begin
          if (att_q == 4'd1) begin
            state_d = ALARM;
            att_d   = 4'd0;
          end else begin
            state_d = LOCKOUT;
            att_d   = att_q - 4'd1;
            cnt_d   = CW'(LOCKOUT_CYCLES);
          end
        end else if (done_now) begin
          if (idx_q == IW'(NUM_PHASES - 1)) begin
            state_d = UNLOCK;
            cnt_d   = CW'(UNLOCK_CYCLES);
            att_d   = 4'(MAX_ATTEMPTS);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      UNLOCK, LOCKOUT: begin
        if (cnt_q == CW'(1))
          state_d = IDLE;
        else
          cnt_d = cnt_q - 1'b1;
      end
      ALARM: begin
        if (bus.admin_clr) begin
          state_d = IDLE;
          att_d   = 4'(MAX_ATTEMPTS);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != RUN)
      idx_d = '0;
    en_d = (state_d == RUN) ? (NUM_PHASES'(1) << idx_d) : '0;
  end

  // All outputs come from registers; the clears power up asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      att_q     <= 4'(MAX_ATTEMPTS);
      en_q      <= '0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      att_q     <= att_d;
      en_q      <= en_d;
      unlock_q  <= (state_d == UNLOCK);
      lockout_q <= (state_d == LOCKOUT);
      alarm_q   <= (state_d == ALARM);
    end
  end

  assign bus.phase_en      = en_q;
  assign bus.phase_clr     = ~en_q;
  assign bus.cur_phase     = idx_q;
  assign bus.unlock        = unlock_q;
  assign bus.lockout       = lockout_q;
  assign bus.alarm         = alarm_q;
  assign bus.attempts_left = att_q;
endmodule

// File: tb/tb_vault_sequencer.sv
// tb/tb_vault_sequencer.sv - directed self-checking bench for vault_sequencer
module tb_vault_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;

  always #5 clk = ~clk;

  vault_sequencer_if #(.NUM_PHASES(3)) vif ();

  vault_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (vif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_lockout(output int cyc);
    cyc = vif.lockout ? 1 : 0;
    while (vif.lockout && cyc < 200) begin
      tick();
      if (vif.lockout) cyc++;
    end
  endtask

  initial begin
    vif.start      = 1'b0;
    vif.admin_clr  = 1'b0;
    vif.phase_done = '0;
    vif.phase_fail = '0;
    repeat (3) tick();

    chk("rst_clr",     vif.phase_clr, 3'b111);
    chk("rst_en",      vif.phase_en, 3'b000);
    chk("rst_att",     vif.attempts_left, 4'd3);
    chk("rst_flags",   {vif.unlock, vif.lockout, vif.alarm, vif.timeout_err}, 4'b0000);
    chk("rst_cur",     vif.cur_phase, 2'd0);

    reset_n = 1'b1;
    tick();

    // successful attempt, done flags in consecutive cycles
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    chk("ok_en0",  vif.phase_en, 3'b001);
    chk("ok_clr0", vif.phase_clr, 3'b110);
    vif.phase_done = 3'b001;
    tick();
    chk("ok_en1",  vif.phase_en, 3'b010);
    chk("ok_cur1", vif.cur_phase, 2'd1);
    vif.phase_done = 3'b010;
    tick();
    chk("ok_en2",  vif.phase_en, 3'b100);
    vif.phase_done = 3'b100;
    tick();
    vif.phase_done = '0;
    chk("ok_unlock", vif.unlock, 1'b1);
    chk("ok_en_off", vif.phase_en, 3'b000);
    chk("ok_att",    vif.attempts_left, 4'd3);
    n = 1;
    while (vif.unlock && n < 200) begin
      tick();
      if (vif.unlock) n++;
    end
    chk("unlock_len", n, 8);
    chk("ok_idle", {vif.unlock, vif.lockout, vif.phase_en}, 5'b0);

    // fail on phase 1, start held through lockout
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    vif.phase_done = 3'b001;
    tick();
    vif.phase_done = 3'b000;
    vif.phase_fail = 3'b010;
    vif.start = 1'b1;
    tick();
    vif.phase_fail = '0;
    chk("f1_lock", vif.lockout, 1'b1);
    chk("f1_att",  vif.attempts_left, 4'd2);
    n = 1;
    while (vif.lockout && n < 200) begin
      chk("f1_no_start", vif.phase_en, 3'b000);
      tick();
      if (vif.lockout) n++;
    end
    chk("lock_len", n, 16);
    chk("f1_idle_en", vif.phase_en, 3'b000);
    tick();
    vif.start = 1'b0;
    chk("restart_en", vif.phase_en, 3'b001);

    // stray done from an inactive phase, then done+fail together
    vif.phase_done = 3'b100;
    tick();
    chk("stray_en", vif.phase_en, 3'b001);
    vif.phase_done = 3'b001;
    vif.phase_fail = 3'b001;
    tick();
    vif.phase_done = '0;
    vif.phase_fail = '0;
    chk("both_lock", vif.lockout, 1'b1);
    chk("both_att",  vif.attempts_left, 4'd1);
    count_lockout(n);
    chk("lock_len2", n, 16);

    // third failure raises the alarm, which ignores start
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    vif.phase_fail = 3'b001;
    tick();
    vif.phase_fail = '0;
    chk("al_alarm", vif.alarm, 1'b1);
    chk("al_att",   vif.attempts_left, 4'd0);
    chk("al_lock",  vif.lockout, 1'b0);
    vif.start = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (vif.alarm && vif.phase_en == 3'b000) n++;
    end
    vif.start = 1'b0;
    chk("al_hold", n, 100);
    vif.admin_clr = 1'b1;
    tick();
    vif.admin_clr = 1'b0;
    chk("al_clr",     vif.alarm, 1'b0);
    chk("al_clr_att", vif.attempts_left, 4'd3);

`ifdef VAULT_TIMEOUT_EN
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    repeat (63) tick();
    chk("to_early", {vif.timeout_err, vif.lockout}, 2'b00);
    tick();
    chk("to_pulse", vif.timeout_err, 1'b1);
    chk("to_lock",  vif.lockout, 1'b1);
    tick();
    chk("to_once",  vif.timeout_err, 1'b0);
    count_lockout(n);
`endif

    // asynchronous reset in the middle of UNLOCK
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    vif.phase_done = 3'b001;
    tick();
    vif.phase_done = 3'b010;
    tick();
    vif.phase_done = 3'b100;
    tick();
    vif.phase_done = '0;
    tick();
    chk("rr_unlock", vif.unlock, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rr_unlock0", vif.unlock, 1'b0);
    chk("rr_clr",     vif.phase_clr, 3'b111);
    tick();
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vault_sequencer.md
# vault_sequencer

Top-level sequencer for the vault's multi-phase unlock path. It releases each phase FSM in order, watches only the active phase's done/fail flags, and counts failed attempts. It drives the unlock hold, the timed lockout after a failure and the sticky alarm after too many failures. It sits above the phase FSMs, whose DONE/FAIL states are terminal, so it also owns their clears.

## Interface
- NUM_PHASES, 3: number of phase FSMs sequenced, indexed 0..NUM_PHASES-1.
- MAX_ATTEMPTS, 3: failed attempts that raise the alarm, 1..15.
- LOCKOUT_CYCLES, 16: lockout duration after a non-final failure, at least 1.
- UNLOCK_CYCLES, 8: cycles that `unlock` is held high, at least 1.
- PHASE_TIMEOUT, 64: maximum cycles per phase, at least 2. Only used under VAULT_TIMEOUT_EN.

- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; begins an attempt when sampled in IDLE.
- admin_clr  in  1  level; clears ALARM only.
- phase_done  in  NUM_PHASES  done flag from each phase FSM.
- phase_fail  in  NUM_PHASES  fail flag from each phase FSM.
- phase_en  out  NUM_PHASES  one-hot select of the active phase; all-zero outside RUN.
- phase_clr  out  NUM_PHASES  clear to each phase FSM; always equals ~phase_en.
- cur_phase  out  $clog2(NUM_PHASES)  index of the active phase; 0 outside RUN.
- unlock  out  1  high during UNLOCK.
- lockout  out  1  high during LOCKOUT.
- alarm  out  1  high during ALARM.
- attempts_left  out  4  MAX_ATTEMPTS minus the failures recorded so far.
- timeout_err  out  1  one-cycle pulse when a phase times out.

## Operation
- **States:** IDLE, RUN, UNLOCK, LOCKOUT, ALARM. All outputs are registered.
- **Reset values:**
  - state = IDLE, cur_phase = 0, phase_en = 0 and phase_clr = all ones.
  - unlock, lockout, alarm and timeout_err are 0.
  - attempts_left = MAX_ATTEMPTS.
- **IDLE:** when start = 1, go to RUN with idx = 0.
- **RUN:** examine only phase_done[idx] and phase_fail[idx]; flags from other phases are ignored.
  - Fail (or timeout) is evaluated first:
    - If attempts_left == 1, go to ALARM with attempts_left = 0.
    - Otherwise decrement attempts_left, load the lockout counter with LOCKOUT_CYCLES and go to LOCKOUT.
  - Otherwise, if done:
    - When idx == NUM_PHASES-1, go to UNLOCK. Load the hold counter with UNLOCK_CYCLES and set attempts_left to MAX_ATTEMPTS.
    - Otherwise increment idx. The completed phase's clear is reasserted and the next phase is released.
  - When done and fail are high in the same cycle, fail wins.
- **UNLOCK:** decrement the hold counter; go to IDLE when it reaches 1. start is ignored.
- **LOCKOUT:** decrement the lockout counter; go to IDLE when it reaches 1. start is ignored.
- **ALARM:** sticky; start is ignored.
  - admin_clr = 1 causes ALARM to IDLE with attempts_left = MAX_ATTEMPTS.
  - admin_clr has no effect in any other state.
- **Reset mid-operation:** any state returns to the reset values immediately. The phase clears assert asynchronously.

## Timing
- Input-to-output latency is 1 cycle. start sampled at edge k gives phase_en[0] = 1 and phase_clr[0] = 0 after edge k.
- phase_done[i] sampled at edge k gives phase_en advancing to i+1 after edge k. A phase is therefore released no earlier than 1 cycle after the previous phase's done is sampled.
- Minimum attempt length, from start sampled to unlock high, is NUM_PHASES+1 edges.
- unlock stays high for exactly UNLOCK_CYCLES cycles. lockout stays high for exactly LOCKOUT_CYCLES cycles.
- start held continuously through the return to IDLE begins a new attempt 1 cycle after IDLE is entered. No edge detection is performed.
- attempts_left updates on the same edge as the state change.

## Configuration
- **VAULT_TIMEOUT_EN defined:**
  - A per-phase cycle counter is cleared whenever a phase is released.
  - If the counter reaches PHASE_TIMEOUT-1 while in RUN with neither flag set, the edge is treated as a fail.
  - That edge also pulses timeout_err for 1 cycle.
- **VAULT_TIMEOUT_EN undefined:** no counter is built, timeout_err is tied to 0, and a phase may wait indefinitely.

## Test plan
- Reset with defaults -> phase_clr = 3'b111, attempts_left = 3, and unlock, lockout and alarm all 0.
- start, then done on phase 0, 1, 2 in consecutive cycles -> phase_en steps 001, 010, 100, then unlock is high for 8 cycles and the block returns to IDLE.
- phase_fail[1] while phase 1 is active -> lockout high for 16 cycles, attempts_left = 2, and start is ignored during lockout.
- Three failed attempts -> on the third, alarm = 1 and attempts_left = 0. alarm holds for 100 cycles and then clears to IDLE with attempts_left = 3 on admin_clr.
- phase_done[0] and phase_fail[0] both high in the same cycle -> LOCKOUT. A stray phase_done[2] while phase 0 is active -> no effect.
- With VAULT_TIMEOUT_EN and PHASE_TIMEOUT = 64: no flags for 64 cycles after release -> timeout_err pulses once and the block enters LOCKOUT.
- reset_n low during UNLOCK -> unlock = 0 immediately and all phase clears are asserted.
